// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and opcode constants for the pc sequencer
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } seq_state_t;

  // cmp is identified by its 3-bit major opcode
  localparam logic [2:0] OP_CMP   = 3'b000;

  // jumps are identified by the upper 5 bits; the low nibble is the LUT index
  localparam logic [4:0] OP_JGE   = 5'b10000;
  localparam logic [4:0] OP_JG    = 5'b10001;
  localparam logic [4:0] OP_JMP   = 5'b10010;

  // data-memory ops are identified by the upper 6 bits
  localparam logic [5:0] OP_LDR_A = 6'b101101;
  localparam logic [5:0] OP_STR_A = 6'b101110;
  localparam logic [5:0] OP_LDR_B = 6'b110000;
  localparam logic [5:0] OP_STR_B = 6'b110001;

  localparam logic [8:0] HALT_OP_DEFAULT = 9'h1FF;

  // true when the 6-bit opcode prefix selects a load or store
  function automatic logic is_mem_op(input logic [5:0] prefix);
    return (prefix == OP_LDR_A) || (prefix == OP_STR_A) ||
           (prefix == OP_LDR_B) || (prefix == OP_STR_B);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - sequencer-side bundle: ROM, jump LUT, ALU flags, decoder strobes (PC_SEQUENCER_PERF_EN adds instr_count)
interface pc_sequencer_if #(
  parameter int PC_W = 10
);

  logic            start;
  logic [8:0]      instr;
  logic [PC_W-1:0] lut_target;
  logic            alu_carry;
  logic            alu_zero;
  logic [PC_W-1:0] pc;
  logic [3:0]      lut_idx;
  logic            exec_en;
  logic            mem_req;
  logic            busy;
  logic            done;
`ifdef PC_SEQUENCER_PERF_EN
  logic [15:0]     instr_count;
`endif

  // sequencer side
  modport master (
    input  start, instr, lut_target, alu_carry, alu_zero,
    output pc, lut_idx, exec_en, mem_req, busy, done
`ifdef PC_SEQUENCER_PERF_EN
    , output instr_count
`endif
  );

  // core / environment side
  modport slave (
    output start, instr, lut_target, alu_carry, alu_zero,
    input  pc, lut_idx, exec_en, mem_req, busy, done
`ifdef PC_SEQUENCER_PERF_EN
    , input instr_count
`endif
  );

endinterface

// File: rtl/pc_sequencer_branch_resolve.sv
// rtl/pc_sequencer_branch_resolve.sv - decodes jump opcodes and evaluates the branch condition
module branch_resolve
  import pc_seq_pkg::*;
(
  input  logic [8:0] instr,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       is_jump,
  output logic       taken
);

  // the low nibble is the LUT index and plays no part in the condition
  logic unused_idx;
  assign unused_idx = ^instr[3:0];

  // jump decode and condition evaluation
  always_comb begin
    is_jump = 1'b0;
    taken   = 1'b0;
    case (instr[8:4])
      OP_JGE: begin
        is_jump = 1'b1;
        taken   = flag_c;
      end
      OP_JG: begin
        is_jump = 1'b1;
        taken   = flag_c & ~flag_z;
      end
      OP_JMP: begin
        is_jump = 1'b1;
        taken   = 1'b1;
      end
      default: begin
        is_jump = 1'b0;
        taken   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/execute sequencer: pc, jump resolution, cmp flags, memory stall (PC_SEQUENCER_PERF_EN adds instr_count)
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int         PC_W    = 10,
  parameter int         MEM_LAT = 1,
  parameter logic [8:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.master bus
);

  localparam logic [PC_W-1:0] PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]      LAT_INIT = 3'(MEM_LAT);
  localparam bit              MEM_STALL = (MEM_LAT > 0);

  seq_state_t      state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt;
  logic            flag_c, flag_z, flag_c_nxt, flag_z_nxt;
  logic [2:0]      wait_cnt, wait_cnt_nxt;
  logic            exec_en, mem_req, done;
  logic            is_jump, taken;
  logic            is_mem, is_halt, is_cmp;
  logic            start_ok;

  assign is_mem   = is_mem_op(bus.instr[8:3]);
  assign is_halt  = (bus.instr == HALT_OP);
  assign is_cmp   = (bus.instr[8:6] == OP_CMP);
  assign start_ok = ((state == IDLE) || (state == HALT)) && bus.start;

  branch_resolve u_branch (
    .instr   (bus.instr),
    .flag_c  (flag_c),
    .flag_z  (flag_z),
    .is_jump (is_jump),
    .taken   (taken)
  );

  // sequencer state, pc, flags and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc_q     <= '0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      pc_q     <= pc_nxt;
      flag_c   <= flag_c_nxt;
      flag_z   <= flag_z_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // next-state and strobes; a stalled memory op commits only on its last cycle
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    flag_c_nxt   = flag_c;
    flag_z_nxt   = flag_z;
    wait_cnt_nxt = wait_cnt;
    exec_en      = 1'b0;
    mem_req      = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (bus.start) begin
          pc_nxt    = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (is_halt) begin
          done      = 1'b1;
          state_nxt = HALT;
        end else if (is_mem && MEM_STALL) begin
          mem_req      = 1'b1;
          wait_cnt_nxt = LAT_INIT;
          state_nxt    = MEM_WAIT;
        end else begin
          exec_en = 1'b1;
          mem_req = is_mem;
          pc_nxt  = (is_jump && taken) ? bus.lut_target : pc_q + PC_ONE;
          if (is_cmp) begin
            flag_c_nxt = bus.alu_carry;
            flag_z_nxt = bus.alu_zero;
          end
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (wait_cnt == 3'd1) begin
          exec_en      = 1'b1;
          pc_nxt       = pc_q + PC_ONE;
          wait_cnt_nxt = 3'd0;
          state_nxt    = RUN;
        end else begin
          wait_cnt_nxt = wait_cnt - 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.pc      = pc_q;
  assign bus.lut_idx = bus.instr[3:0];
  assign bus.exec_en = exec_en;
  assign bus.mem_req = mem_req;
  assign bus.done    = done;
  assign bus.busy    = (state == RUN) || (state == MEM_WAIT);

`ifdef PC_SEQUENCER_PERF_EN
  logic [15:0] instr_count;

  // committed-instruction counter, saturating, cleared on each accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= 16'd0;
    end else if (start_ok) begin
      instr_count <= 16'd0;
    end else if (exec_en && (instr_count != 16'hFFFF)) begin
      instr_count <= instr_count + 16'd1;
    end
  end

  assign bus.instr_count = instr_count;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer (MEM_LAT=2 and MEM_LAT=0 instances)
module tb_pc_sequencer;

  localparam int         PC_W  = 10;
  localparam int         DEPTH = 1 << PC_W;
  localparam logic [8:0] HALT  = 9'h1FF;
  localparam logic [8:0] I_ADD = 9'h040;
  localparam logic [8:0] I_CMP = 9'h012;
  localparam logic [8:0] I_LDR = 9'h168;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, carry, zero;
  logic [8:0]      rom [0:DEPTH-1];
  logic [PC_W-1:0] lut [0:15];
  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer_if #(.PC_W(PC_W)) bus2 ();
  pc_sequencer_if #(.PC_W(PC_W)) bus0 ();

  assign bus2.start      = start;
  assign bus2.instr      = rom[bus2.pc];
  assign bus2.lut_target = lut[bus2.lut_idx];
  assign bus2.alu_carry  = carry;
  assign bus2.alu_zero   = zero;
  assign bus0.start      = start;
  assign bus0.instr      = rom[bus0.pc];
  assign bus0.lut_target = lut[bus0.lut_idx];
  assign bus0.alu_carry  = carry;
  assign bus0.alu_zero   = zero;

  pc_sequencer #(.PC_W(PC_W), .MEM_LAT(2), .HALT_OP(HALT)) dut2 (
    .clk (clk), .rst_n (rst_n), .bus (bus2.master)
  );
  pc_sequencer #(.PC_W(PC_W), .MEM_LAT(0), .HALT_OP(HALT)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0.master)
  );

  function automatic logic [8:0] jge(input int idx); return {5'b10000, 4'(idx)}; endfunction
  function automatic logic [8:0] jg (input int idx); return {5'b10001, 4'(idx)}; endfunction
  function automatic logic [8:0] jmp(input int idx); return {5'b10010, 4'(idx)}; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cnt2();
`ifdef PC_SEQUENCER_PERF_EN
    return bus2.instr_count;
`else
    return 16'd0;
`endif
  endfunction
  function automatic logic [15:0] cnt0();
`ifdef PC_SEQUENCER_PERF_EN
    return bus0.instr_count;
`else
    return 16'd0;
`endif
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct { bit run; int pc; bit c; bit z; int el; int cnt; } mdl_t;
  typedef struct { int pc; bit ex; bit mem; bit busy; bit done; int cnt; } out_t;

  // one instruction lasts lat+1 cycles for memory ops, 1 otherwise; commit is the last cycle
  function automatic void model(input mdl_t m, input int lat, input bit st, input bit ac,
                                input bit az, output out_t o, output mdl_t n);
    logic [8:0] ins;
    bit mem_op, tk;
    n = m;
    o = '{m.pc, 1'b0, 1'b0, 1'b0, 1'b0, m.cnt};
    if (!m.run) begin
      if (st) begin
        n.run = 1'b1; n.pc = 0; n.el = 0; n.cnt = 0;
      end
    end else begin
      o.busy = 1'b1;
      ins    = rom[m.pc];
      mem_op = ins[8:3] inside {6'b101101, 6'b101110, 6'b110000, 6'b110001};
      if (ins == HALT) begin
        o.done = 1'b1;
        n.run  = 1'b0;
      end else if (mem_op && (m.el < lat)) begin
        o.mem = 1'b1;
        n.el  = m.el + 1;
      end else begin
        o.mem = mem_op;
        o.ex  = 1'b1;
        n.el  = 0;
        n.cnt = (m.cnt == 65535) ? m.cnt : m.cnt + 1;
        tk = (ins[8:4] == 5'b10010) || (ins[8:4] == 5'b10000 && m.c) ||
             (ins[8:4] == 5'b10001 && m.c && !m.z);
        n.pc = tk ? int'(lut[ins[3:0]]) : (m.pc + 1) % DEPTH;
        if (ins[8:6] == 3'b000) begin
          n.c = ac; n.z = az;
        end
      end
    end
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct { bit st; bit c; bit z; int pc; bit ex; bit mem; bit busy; bit done; int cnt; } vec_t;
  vec_t vt [18];

  mdl_t m2, m0, n2, n0;
  out_t o2, o0;
  int   r;
  logic [8:0] ri;

  initial begin
    rst_n = 1'b0; start = 1'b0; carry = 1'b0; zero = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom[i] = I_ADD;
    for (int i = 0; i < 16; i++) lut[i] = 10'h3C0;
    rom[3]     = I_CMP;
    rom[4]     = jge(3);   lut[3] = 10'h020;
    rom[10'h20] = I_CMP;
    rom[10'h21] = jg(4);
    rom[10'h22] = I_CMP;
    rom[10'h23] = jge(3);
    rom[10'h24] = jmp(5);  lut[5] = 10'h030;
    rom[10'h30] = I_LDR;
    rom[10'h31] = HALT;

    //          st c  z  pc     ex mem busy done cnt
    vt[0]  = '{1, 0, 0, 'h000, 0, 0,  0,   0,   0};
    vt[1]  = '{0, 0, 0, 'h000, 1, 0,  1,   0,   0};
    vt[2]  = '{0, 0, 0, 'h001, 1, 0,  1,   0,   1};
    vt[3]  = '{0, 0, 0, 'h002, 1, 0,  1,   0,   2};
    vt[4]  = '{0, 1, 1, 'h003, 1, 0,  1,   0,   3};
    vt[5]  = '{0, 0, 0, 'h004, 1, 0,  1,   0,   4};
    vt[6]  = '{0, 1, 1, 'h020, 1, 0,  1,   0,   5};
    vt[7]  = '{0, 0, 0, 'h021, 1, 0,  1,   0,   6};
    vt[8]  = '{0, 0, 0, 'h022, 1, 0,  1,   0,   7};
    vt[9]  = '{0, 0, 0, 'h023, 1, 0,  1,   0,   8};
    vt[10] = '{0, 0, 0, 'h024, 1, 0,  1,   0,   9};
    vt[11] = '{0, 0, 0, 'h030, 0, 1,  1,   0,   10};
    vt[12] = '{0, 0, 0, 'h030, 0, 1,  1,   0,   10};
    vt[13] = '{0, 0, 0, 'h030, 1, 1,  1,   0,   10};
    vt[14] = '{0, 0, 0, 'h031, 0, 0,  1,   1,   11};
    vt[15] = '{0, 0, 0, 'h031, 0, 0,  0,   0,   11};
    vt[16] = '{1, 0, 0, 'h031, 0, 0,  0,   0,   11};
    vt[17] = '{0, 0, 0, 'h000, 1, 0,  1,   0,   0};

    // reset state and idle hold
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", bus2.pc, 0);
    chk("rst_busy", bus2.busy, 0);
    chk("rst_exec", bus2.exec_en, 0);
    chk("rst_done", bus2.done, 0);
    chk("rst_mem", bus2.mem_req, 0);
`ifdef PC_SEQUENCER_PERF_EN
    chk("rst_cnt", bus2.instr_count, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("idle_busy", bus2.busy, 0);
      chk("idle_pc", bus2.pc, 0);
    end

    // directed program
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      start = vt[i].st; carry = vt[i].c; zero = vt[i].z;
      #1;
      chk($sformatf("vec%0d_pc", i),   bus2.pc,      vt[i].pc);
      chk($sformatf("vec%0d_exec", i), bus2.exec_en, vt[i].ex);
      chk($sformatf("vec%0d_mem", i),  bus2.mem_req, vt[i].mem);
      chk($sformatf("vec%0d_busy", i), bus2.busy,    vt[i].busy);
      chk($sformatf("vec%0d_done", i), bus2.done,    vt[i].done);
`ifdef PC_SEQUENCER_PERF_EN
      chk($sformatf("vec%0d_cnt", i),  bus2.instr_count, vt[i].cnt);
`endif
      if (i == 11) begin
        chk("lat0_ldr_pc", bus0.pc, 'h030);
        chk("lat0_ldr_exec", bus0.exec_en, 1);
        chk("lat0_ldr_mem", bus0.mem_req, 1);
      end
      if (i == 12) begin
        chk("lat0_halt_pc", bus0.pc, 'h031);
        chk("lat0_halt_done", bus0.done, 1);
      end
    end
    start = 1'b0;

    // reset while in MEM_WAIT abandons the load
    @(negedge clk) rst_n = 1'b0;
    rom[0] = jmp(6); lut[6] = 10'h005; rom[5] = I_LDR;
    @(negedge clk) begin rst_n = 1'b1; start = 1'b1; end
    @(negedge clk) start = 1'b0;
    #1 chk("mw_jmp_exec", bus2.exec_en, 1);
    @(negedge clk); #1;
    chk("mw_first_pc", bus2.pc, 5);
    chk("mw_first_exec", bus2.exec_en, 0);
    @(negedge clk); #1;
    chk("mw_wait_mem", bus2.mem_req, 1);
    chk("mw_wait_exec", bus2.exec_en, 0);
    rst_n = 1'b0;
    #1;
    chk("mw_rst_pc", bus2.pc, 0);
    chk("mw_rst_mem", bus2.mem_req, 0);
    chk("mw_rst_exec", bus2.exec_en, 0);
    chk("mw_rst_busy", bus2.busy, 0);
    chk("mw_rst_pc0", bus0.pc, 0);
`ifdef PC_SEQUENCER_PERF_EN
    chk("mw_rst_cnt", bus2.instr_count, 0);
`endif
    @(posedge clk); @(negedge clk); #1;
    chk("mw_nocommit", bus2.exec_en, 0);

    // pc wrap from the top of the ROM
    rom[0] = jmp(7); lut[7] = 10'h3FF; rom[10'h3FF] = I_ADD;
    @(negedge clk) begin rst_n = 1'b1; start = 1'b1; end
    @(negedge clk) start = 1'b0;
    #1 chk("wrap_pc0", bus2.pc, 0);
    @(negedge clk); #1;
    chk("wrap_top", bus2.pc, 10'h3FF);
    chk("wrap_top_exec", bus2.exec_en, 1);
    @(negedge clk); #1;
    chk("wrap_pc", bus2.pc, 0);

    // self-loop jump
    rst_n = 1'b0;
    rom[0] = jmp(8); lut[8] = 10'h000;
    @(negedge clk) begin rst_n = 1'b1; start = 1'b1; end
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("self_pc", bus2.pc, 0);
      chk("self_exec", bus2.exec_en, 1);
    end

    // randomized program against the reference model
    rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom_range(0, 99);
      ri = 9'($urandom);
      if (r < 30)      rom[i] = {3'b001, ri[5:0]};
      else if (r < 50) rom[i] = {3'b000, ri[5:0]};
      else if (r < 70) rom[i] = {3'b100, 2'($urandom_range(0, 2)), ri[3:0]};
      else if (r < 85) rom[i] = {(ri[8:7] == 2'd0) ? 6'b101101 : (ri[8:7] == 2'd1) ? 6'b101110 :
                                 (ri[8:7] == 2'd2) ? 6'b110000 : 6'b110001, ri[2:0]};
      else if (r < 88) rom[i] = HALT;
      else             rom[i] = ri;
    end
    for (int i = 0; i < 16; i++) lut[i] = PC_W'($urandom);
    m2 = '{1'b0, 0, 1'b0, 1'b0, 0, 0};
    m0 = m2;
    @(negedge clk) rst_n = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      start = ($urandom_range(0, 9) == 0);
      carry = 1'($urandom);
      zero  = 1'($urandom);
      #1;
      model(m2, 2, start, carry, zero, o2, n2);
      model(m0, 0, start, carry, zero, o0, n0);
      chk("rnd2_pc", bus2.pc, o2.pc);
      chk("rnd2_exec", bus2.exec_en, o2.ex);
      chk("rnd2_mem", bus2.mem_req, o2.mem);
      chk("rnd2_busy", bus2.busy, o2.busy);
      chk("rnd2_done", bus2.done, o2.done);
      chk("rnd0_pc", bus0.pc, o0.pc);
      chk("rnd0_exec", bus0.exec_en, o0.ex);
      chk("rnd0_mem", bus0.mem_req, o0.mem);
      chk("rnd0_busy", bus0.busy, o0.busy);
      chk("rnd0_done", bus0.done, o0.done);
`ifdef PC_SEQUENCER_PERF_EN
      chk("rnd2_cnt", cnt2(), o2.cnt);
      chk("rnd0_cnt", cnt0(), o0.cnt);
`endif
      m2 = n2;
      m0 = n0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle fetch/execute sequencer for the 9-bit-instruction core. It owns the program counter and resolves jge/jg/jmp through a 16-entry jump LUT. It holds the condition flags produced by cmp and stalls the core for data-memory latency on ldr/str. It sits between the instruction ROM, the jump LUT, the instruction decoder (whose write enables are qualified by exec_en) and the ALU flag outputs.

Parameters:
PC_W, 10, program counter width; instruction ROM depth 2**PC_W.
MEM_LAT, 1, extra wait cycles for ldr/str (0..7); 0 makes memory ops single-cycle.
HALT_OP, 9'h1FF, instruction encoding that ends the program.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin execution at pc=0; honoured only in IDLE or HALT.
instr  in  9  instruction at pc (asynchronous ROM read, valid in the same cycle).
lut_target  in  PC_W  jump LUT output for lut_idx (combinational).
alu_carry  in  1  ALU adder carry-out.
alu_zero  in  1  ALU result == 0.
pc  out  PC_W  current program counter.
lut_idx  out  4  instr[3:0], drives the jump LUT.
exec_en  out  1  commit strobe; register/data-memory writes of the current instr happen only while high.
mem_req  out  1  high on every cycle of an ldr/str instruction.
busy  out  1  high in RUN or MEM_WAIT.
done  out  1  one-cycle pulse when HALT_OP is reached.

Behaviour:
- Reset values (asynchronous, rst_n low): pc=0, state=IDLE, flag_c=0, flag_z=0, wait counter=0, exec_en=0, mem_req=0, busy=0, done=0. Reset mid-instruction abandons it with no commit.
- States: IDLE, RUN, MEM_WAIT, HALT.
- IDLE/HALT: pc held. When start=1, pc<=0 and go to RUN. exec_en=0 in both states.
- RUN, non-memory and non-halt instruction: exec_en=1 for one cycle; pc updates on the next edge.
  - Jump opcodes are instr[8:4] = 10000 (jge), 10001 (jg), 10010 (jmp).
  - Taken jump: pc<=lut_target. Not-taken jump: pc<=pc+1.
  - jmp is always taken. jge is taken if flag_c=1. jg is taken if flag_c=1 and flag_z=0.
  - All other opcodes: pc<=pc+1.
- Flags: on the commit cycle of cmp (instr[8:6]=000), flag_c<=alu_carry and flag_z<=alu_zero. No other opcode changes the flags.
- Memory ops: instr[8:3] in {101101, 101110, 110000, 110001}.
  - With MEM_LAT=0: handled as a single-cycle op, with mem_req=1 alongside exec_en.
  - With MEM_LAT>0: first cycle has mem_req=1, exec_en=0, counter<=MEM_LAT, then go to MEM_WAIT.
  - MEM_WAIT: mem_req=1, counter decrements each cycle. On the cycle counter==1: exec_en=1, pc<=pc+1, return to RUN.
  - Total instruction length is MEM_LAT+1 cycles; pc and instr are stable throughout.
- Halt: in RUN with instr==HALT_OP: exec_en=0, done=1 for that cycle, go to HALT. pc stays at the halt address.
- pc+1 wraps from 2**PC_W-1 to 0 silently. A lut_target equal to the current pc is a legal self-loop.
- start while busy: ignored.
- busy=1 exactly in RUN and MEM_WAIT.

Optional Feature:
Macro PC_SEQUENCER_PERF_EN.
- Defined: adds output port instr_count [15:0]. It increments (saturating at 16'hFFFF) on every exec_en cycle, clears to 0 on reset and whenever start is accepted, and holds in IDLE/HALT.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pc_seq_pkg holds:
  - the state enum (IDLE, RUN, MEM_WAIT, HALT);
  - opcode-prefix constants OP_CMP, OP_JGE, OP_JG, OP_JMP, OP_LDR_A, OP_STR_A, OP_LDR_B, OP_STR_B;
  - the default HALT_OP.
- One natural sub-module: branch_resolve (combinational). Inputs: instr, flag_c, flag_z. Outputs: is_jump, taken. The FSM and counters stay in pc_sequencer.

Test Plan:
1. Reset: hold rst_n=0, then release -> pc=0, busy=0, exec_en=0, done=0, mem_req=0; start=0 keeps state IDLE for 10 cycles.
2. start with ROM = add, add, add -> pc goes 0,1,2,3 on consecutive cycles; exec_en=1 each cycle; busy=1.
3. cmp with alu_carry=1, alu_zero=1, then jge idx 3 with lut_target=0x020 -> pc=0x020. Repeat with jg -> not taken, pc=cmp_addr+2. Repeat jge with alu_carry=0 -> not taken.
4. MEM_LAT=2, ldr at pc=4 -> mem_req=1 for 3 cycles, exec_en=1 only on cycle 3, pc=5 after; at MEM_LAT=0 the same ldr takes 1 cycle.
5. HALT_OP at pc=7 -> done pulses one cycle, pc stays 7, busy=0. Pulse start -> pc=0, RUN. Separately, pc=2**PC_W-1 with a non-jump instr wraps pc to 0.
6. Assert rst_n=0 during MEM_WAIT -> immediately pc=0, mem_req=0, exec_en=0, and no commit occurs. With PC_SEQUENCER_PERF_EN, instr_count after test 2 equals 3 and clears on restart.
